// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N-input W-bit select with registered valid/ready output.
// A 2-entry skid keeps in_ready free of any out_ready path.
//
// Ports:
//   clk, reset  rising-edge clock, sync active-high reset
//   in_data     N_IN packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel      select; values >= N_IN yield OOR_VAL with oor tag
//   in_valid    input handshake valid
//   in_ready    input handshake ready (registered, = ~skid valid)
//   out_data    selected data
//   out_sel     select that produced out_data
//   out_oor     out_data came from an out-of-range select
//   out_valid   output handshake valid
//   out_ready   output handshake ready
//   oor_cnt     saturating count of accepted out-of-range selects
module pipe_mux_n #(
  parameter int              WIDTH   = 32,
  parameter int              N_IN    = 7,
  parameter int              SEL_W   = 3,
  parameter logic [WIDTH-1:0] OOR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_oor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            oor_cnt
);

  logic [WIDTH-1:0] muxData;
  logic             muxOor;

  logic             skidValid;
  logic [WIDTH-1:0] skidData;
  logic [SEL_W-1:0] skidSel;
  logic             skidOor;

  logic accept;
  logic drain;

  // Unmatched select falls through to OOR_VAL.
  always_comb begin
    muxData = OOR_VAL;
    muxOor  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        muxData = in_data[k*WIDTH +: WIDTH];
        muxOor  = 1'b0;
      end
    end
  end

  assign in_ready = ~skidValid;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_oor   <= 1'b0;
      skidValid <= 1'b0;
      skidData  <= '0;
      skidSel   <= '0;
      skidOor   <= 1'b0;
      oor_cnt   <= '0;
    end else begin
      if (accept && muxOor && oor_cnt != 8'hFF)
        oor_cnt <= oor_cnt + 8'd1;

      if (skidValid) begin
        // FULL: skid entry is older, promote it on drain.
        if (drain) begin
          out_data  <= skidData;
          out_sel   <= skidSel;
          out_oor   <= skidOor;
          skidValid <= 1'b0;
        end
      end else if (accept) begin
        if (!out_valid || drain) begin
          out_valid <= 1'b1;
          out_data  <= muxData;
          out_sel   <= in_sel;
          out_oor   <= muxOor;
        end else begin
          skidValid <= 1'b1;
          skidData  <= muxData;
          skidSel   <= in_sel;
          skidOor   <= muxOor;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
